usb_tx_line_encoder: RTL and testbench

- Serial back end of the USB full-speed transmitter; sits directly downstream of the byte register.
- Consumes the byte register's serial output one bit per bit-time and applies bit stuffing and NRZI encoding.
- Drives the D+/D- line pair, including the SE0/J end-of-packet sequence.
- Generates the byte register's shift strobe and a byte-boundary pulse that the TX FSM uses to load the next byte.

---
 rtl/usb_tx_line_encoder.sv | 159 +++++++++++++++
 tb/tb_usb_tx_line_encoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_line_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : usb_tx_line_encoder
//  Brief    : USB full-speed serial back end. Takes one bit per bit-time
//             from the byte register, applies bit stuffing and NRZI, and
//             drives D+/D- including the SE0/SE0/J end-of-packet sequence.
//             Produces the byte register shift strobe and byte-boundary pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module usb_tx_line_encoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tx_active,
  input  logic eop_req,
  input  logic serial_in,
  output logic shift_enable,
  output logic byte_done,
  output logic eop_done,
  output logic busy,
  output logic d_plus,
  output logic d_minus
);

  localparam int                    c_TIMER_W   = $clog2(CLKS_PER_BIT);
  localparam logic [c_TIMER_W-1:0]  c_TIMER_MAX = c_TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]            c_STUFF_RUN = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX      = 2'd1,
    S_EOP_SE0 = 2'd2,
    S_EOP_J   = 2'd3
  } state_t;

  state_t                r_state,  w_state_nxt;
  logic [c_TIMER_W-1:0]  r_timer,  w_timer_nxt;
  logic [2:0]            r_ones,   w_ones_nxt;   // consecutive ones on the line
  logic [2:0]            r_bits,   w_bits_nxt;   // data bit index in byte / SE0 bit-time count
  logic                  r_dp,     w_dp_nxt;
  logic                  r_dm,     w_dm_nxt;
  logic                  w_boundary;

  assign w_boundary = (r_timer == c_TIMER_MAX);

  // State, bit timer, counters and registered line pair
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_ones  <= '0;
      r_bits  <= '0;
      r_dp    <= 1'b1;
      r_dm    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_ones  <= w_ones_nxt;
      r_bits  <= w_bits_nxt;
      r_dp    <= w_dp_nxt;
      r_dm    <= w_dm_nxt;
    end
  end

  // Next-state, next line level and same-clk strobes evaluated on bit boundaries
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = w_boundary ? '0 : r_timer + c_TIMER_W'(1);
    w_ones_nxt   = r_ones;
    w_bits_nxt   = r_bits;
    w_dp_nxt     = r_dp;
    w_dm_nxt     = r_dm;
    shift_enable = 1'b0;
    byte_done    = 1'b0;
    eop_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        w_ones_nxt  = '0;
        w_bits_nxt  = '0;
        w_dp_nxt    = 1'b1;
        w_dm_nxt    = 1'b0;
        if (tx_active) begin
          w_state_nxt = S_TX;
        end
      end

      S_TX: begin
        if (!tx_active) begin
          // Abort: back to idle J immediately, no EOP
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_ones_nxt  = '0;
          w_bits_nxt  = '0;
          w_dp_nxt    = 1'b1;
          w_dm_nxt    = 1'b0;
        end else if (w_boundary) begin
          if (r_ones == c_STUFF_RUN) begin
            // Stuffed zero: toggle without consuming a data bit
            w_dp_nxt   = ~r_dp;
            w_dm_nxt   = ~r_dm;
            w_ones_nxt = '0;
          end else if (eop_req && (r_bits == 3'd0)) begin
            w_state_nxt = S_EOP_SE0;
            w_timer_nxt = '0;
            w_dp_nxt    = 1'b0;
            w_dm_nxt    = 1'b0;
          end else begin
            shift_enable = 1'b1;
            byte_done    = (r_bits == 3'd7);
            w_bits_nxt   = r_bits + 3'd1;
            if (serial_in) begin
              w_ones_nxt = r_ones + 3'd1;
            end else begin
              w_dp_nxt   = ~r_dp;
              w_dm_nxt   = ~r_dm;
              w_ones_nxt = '0;
            end
          end
        end
      end

      S_EOP_SE0: begin
        if (w_boundary) begin
          if (r_bits == 3'd1) begin
            w_state_nxt = S_EOP_J;
            w_bits_nxt  = '0;
            w_dp_nxt    = 1'b1;
            w_dm_nxt    = 1'b0;
          end else begin
            w_bits_nxt  = r_bits + 3'd1;
          end
        end
      end

      S_EOP_J: begin
        if (w_boundary) begin
          eop_done    = 1'b1;
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_ones_nxt  = '0;
          w_bits_nxt  = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy    = (r_state != S_IDLE);
  assign d_plus  = r_dp;
  assign d_minus = r_dm;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_line_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_usb_tx_line_encoder
//  Brief    : Self-checking bench for usb_tx_line_encoder. Expected line
//             symbols come from a bitstream model (NRZI + stuffing over the
//             whole packet); a byte-register model feeds serial_in.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_line_encoder;

  localparam int C = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic tx_active;
  logic eop_req;
  logic serial_in;
  logic shift_enable;
  logic byte_done;
  logic eop_done;
  logic busy;
  logic d_plus;
  logic d_minus;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt[$];
  logic [1:0] exp_sym[$];   // {d_plus, d_minus} per bit-time
  int         exp_kind[$];  // 0 data, 1 last data bit of byte, 2 stuff, 3 eop

  usb_tx_line_encoder #(.CLKS_PER_BIT(C)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_active    (tx_active),
    .eop_req      (eop_req),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .byte_done    (byte_done),
    .eop_done     (eop_done),
    .busy         (busy),
    .d_plus       (d_plus),
    .d_minus      (d_minus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bitstream model: LSB-first bits, a zero toggles the line, six ones in a
  // row force an extra toggle; optional SE0, SE0, J appended.
  function automatic void build_model(input bit do_eop);
    logic lvl;
    int   run;
    exp_sym.delete();
    exp_kind.delete();
    lvl = 1'b1;
    run = 0;
    foreach (pkt[b]) begin
      for (int k = 0; k < 8; k++) begin
        if (pkt[b][k]) run++;
        else begin lvl = ~lvl; run = 0; end
        exp_sym.push_back({lvl, ~lvl});
        exp_kind.push_back((k == 7) ? 1 : 0);
        if (run == 6) begin
          lvl = ~lvl;
          run = 0;
          exp_sym.push_back({lvl, ~lvl});
          exp_kind.push_back(2);
        end
      end
    end
    if (do_eop) begin
      exp_sym.push_back(2'b00); exp_kind.push_back(3);
      exp_sym.push_back(2'b00); exp_kind.push_back(3);
      exp_sym.push_back(2'b10); exp_kind.push_back(3);
    end
  endfunction

  task automatic run_packet(input bit do_eop, input int abort_after);
    int n, total, limit, abort_n, i, nb, idx, nsym;
    int cnt_se, cnt_bd, cnt_ed;
    logic [7:0] sh;
    logic se_prev, bd_prev, drop, raise_eop, lower_all;
    logic [1:0] e_line;
    logic e_busy, e_se, e_bd, e_ed;
    build_model(do_eop);
    nb = pkt.size();
    nsym = exp_sym.size();
    total = C * (nsym + 1);
    limit = total + 4;
    abort_n = -1;
    sh = pkt[0];
    idx = 1;
    cnt_se = 0; cnt_bd = 0; cnt_ed = 0;
    se_prev = 0; bd_prev = 0; drop = 0; raise_eop = 0; lower_all = 0;
    @(posedge clk); #1;
    serial_in = sh[0];
    eop_req = 1'b0;
    tx_active = 1'b1;
    n = 0;
    while (n < limit) begin
      @(posedge clk); n++; #1;
      if (bd_prev) begin
        if (idx < nb) begin sh = pkt[idx]; idx++; end
      end else if (se_prev) begin
        sh = sh >> 1;
      end
      serial_in = sh[0];
      if (drop) begin tx_active = 1'b0; drop = 0; end
      if (raise_eop) begin eop_req = 1'b1; raise_eop = 0; end
      if (lower_all) begin tx_active = 1'b0; eop_req = 1'b0; lower_all = 0; end
      @(negedge clk);
      e_se = 0; e_bd = 0; e_ed = 0;
      if ((abort_n > 0 && n >= abort_n) || n > total) begin
        e_line = 2'b10; e_busy = 0;
      end else begin
        e_busy = 1;
        i = (n - 1 - C) / C;
        e_line = (n <= C || i >= nsym) ? 2'b10 : exp_sym[i];
        if (n % C == 0) begin
          i = n / C - 1;
          if (i < nsym) begin
            e_se = (exp_kind[i] <= 1);
            e_bd = (exp_kind[i] == 1);
          end else begin
            e_ed = do_eop;
          end
        end
      end
      check($sformatf("line n=%0d", n), {d_plus, d_minus}, e_line);
      check($sformatf("busy n=%0d", n), busy, e_busy);
      check($sformatf("shift_enable n=%0d", n), shift_enable, e_se);
      check($sformatf("byte_done n=%0d", n), byte_done, e_bd);
      check($sformatf("eop_done n=%0d", n), eop_done, e_ed);
      cnt_se += int'(shift_enable);
      cnt_bd += int'(byte_done);
      cnt_ed += int'(eop_done);
      se_prev = shift_enable;
      bd_prev = byte_done;
      if (do_eop && byte_done && cnt_bd == nb) raise_eop = 1;
      if (eop_done) lower_all = 1;
      if (abort_after > 0 && shift_enable && cnt_se == abort_after && abort_n < 0) begin
        drop = 1;
        abort_n = n + 2;
        limit = n + 8;
      end
    end
    tx_active = 1'b0;
    eop_req = 1'b0;
    check("shift_count", cnt_se, (abort_after > 0) ? abort_after : 8 * nb);
    check("byte_done_count", cnt_bd, (abort_after > 0) ? abort_after / 8 : nb);
    check("eop_done_count", cnt_ed, (do_eop && abort_after == 0) ? 1 : 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bit found;
    int nb;
    n_rst = 1'b0;
    tx_active = 1'b0;
    eop_req = 1'b0;
    serial_in = 1'b0;
    #12;
    check("rst d_plus", d_plus, 1);
    check("rst d_minus", d_minus, 0);
    check("rst busy", busy, 0);
    check("rst shift_enable", shift_enable, 0);
    check("rst byte_done", byte_done, 0);
    check("rst eop_done", eop_done, 0);
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // Asynchronous reset while the line is at K
    @(posedge clk); #1;
    serial_in = 1'b0;
    tx_active = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (d_minus === 1'b1) found = 1;
    end
    check("reset_wait_k", found, 1);
    #2 n_rst = 1'b0;
    #1;
    check("midrst d_plus", d_plus, 1);
    check("midrst d_minus", d_minus, 0);
    check("midrst busy", busy, 0);
    check("midrst shift_enable", shift_enable, 0);
    check("midrst byte_done", byte_done, 0);
    check("midrst eop_done", eop_done, 0);
    tx_active = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // SYNC then all ones (stuffing inside the byte), EOP
    pkt = {8'h80, 8'hFF};
    run_packet(1, 0);
    // Trailing six ones: stuffed bit precedes EOP
    pkt = {8'h80, 8'h00, 8'hFC};
    run_packet(1, 0);
    // Single byte of zeros: toggle every bit-time
    pkt = {8'h00};
    run_packet(1, 0);
    // Abort at bit 3 of the second byte
    pkt = {8'h80, 8'h5A, 8'h33};
    run_packet(0, 11);

    // Randomized packets, alternating EOP and abort endings
    for (int r = 0; r < 8; r++) begin
      nb = $urandom_range(1, 4);
      pkt.delete();
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) pkt.push_back(8'hFF);
        else pkt.push_back(8'($urandom));
      end
      if (r % 2 == 0) run_packet(1, 0);
      else run_packet(0, $urandom_range(1, 8 * nb - 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
